// File: rtl/rv_alu_pkg.sv
// Shared constants and types for the ALU issue unit: ALU op codes,
// RV32 opcode/funct fields, instruction kinds and FSM states.
package rv_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        KIND_ALU = 2'd0,
        KIND_BEQ = 2'd1,
        KIND_BNE = 2'd2
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32 decode for the supported ALU subset: produces the ALU
// op, whether operand B is the I-type immediate, the instruction kind and
// an illegal flag for everything outside the subset.
module alu_decoder
    import rv_alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_op,
    output logic       o_imm_sel,
    output kind_e      o_kind,
    output logic       o_illegal
);

    // Decode table; anything not explicitly matched stays illegal.
    always_comb begin
        o_op      = ALU_ADD;
        o_imm_sel = 1'b0;
        o_kind    = KIND_ALU;
        o_illegal = 1'b1;
        case (i_opcode)
            OPC_OP: begin
                if (i_funct3 == F3_ADD && i_funct7 == F7_BASE) begin
                    o_op = ALU_ADD; o_illegal = 1'b0;
                end else if (i_funct3 == F3_ADD && i_funct7 == F7_SUB) begin
                    o_op = ALU_SUB; o_illegal = 1'b0;
                end else if (i_funct3 == F3_AND && i_funct7 == F7_BASE) begin
                    o_op = ALU_AND; o_illegal = 1'b0;
                end else if (i_funct3 == F3_OR && i_funct7 == F7_BASE) begin
                    o_op = ALU_OR; o_illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                o_imm_sel = 1'b1;
                if (i_funct3 == F3_ADD) begin
                    o_op = ALU_ADD; o_illegal = 1'b0;
                end else if (i_funct3 == F3_AND) begin
                    o_op = ALU_AND; o_illegal = 1'b0;
                end else if (i_funct3 == F3_OR) begin
                    o_op = ALU_OR; o_illegal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                o_op = ALU_SUB;
                if (i_funct3 == F3_BEQ) begin
                    o_kind = KIND_BEQ; o_illegal = 1'b0;
                end else if (i_funct3 == F3_BNE) begin
                    o_kind = KIND_BNE; o_illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Single-outstanding ALU issue unit: accepts one instruction, drives an
// external ALU from registered operands, captures its result and presents
// it until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a request; ALU registers hold the last legal issue
// EXEC  | ALU driven from registers; result and zero flag captured at end
// RESP  | response valid and held until out_ready_i
module alu_issue_unit
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_op_o,
    input  logic [XLEN-1:0] alu_c_i,
    input  logic            alu_zero_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            branch_taken_o,
    output logic            illegal_o
);

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [3:0]      r_op;
    kind_e           r_kind;
    logic [XLEN-1:0] r_result;
    logic            r_taken;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic            w_imm_sel;
    kind_e           w_kind;
    logic            w_illegal;
    logic            w_accept;
    logic [XLEN-1:0] w_imm;
    logic            w_unused_bits;

    alu_decoder u_dec (
        .i_opcode  (instr_i[6:0]),
        .i_funct3  (instr_i[14:12]),
        .i_funct7  (instr_i[31:25]),
        .o_op      (w_op),
        .o_imm_sel (w_imm_sel),
        .o_kind    (w_kind),
        .o_illegal (w_illegal)
    );

    assign w_imm         = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign w_accept      = in_valid_i & in_ready_o;
    // Register-index fields are irrelevant here: operands arrive as data.
    assign w_unused_bits = ^{instr_i[19:15], instr_i[11:7]};

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) w_state_next = w_illegal ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch on accept and result capture at the end of EXEC.
    // An illegal request leaves the ALU registers untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ALU_ADD;
            r_kind    <= KIND_ALU;
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            if (w_illegal) begin
                r_result  <= '0;
                r_taken   <= 1'b0;
                r_illegal <= 1'b1;
            end else begin
                r_a       <= rs1_data_i;
                r_b       <= w_imm_sel ? w_imm : rs2_data_i;
                r_op      <= w_op;
                r_kind    <= w_kind;
                r_illegal <= 1'b0;
            end
        end else if (r_state == ST_EXEC) begin
            r_result <= alu_c_i;
            r_taken  <= ((r_kind == KIND_BEQ) &  alu_zero_i) |
                        ((r_kind == KIND_BNE) & ~alu_zero_i);
        end
    end

    assign alu_a_o        = r_a;
    assign alu_b_o        = r_b;
    assign alu_op_o       = r_op;
    assign result_o       = r_result;
    assign branch_taken_o = r_taken;
    assign illegal_o      = r_illegal;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: acts as the external ALU, keeps a
// transaction-level reference model, and runs directed plus random traffic.
module tb_alu_issue_unit;

    typedef struct packed {
        logic        legal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        taken;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready, out_valid, taken, illegal, alu_zero;
    logic [31:0] alu_a, alu_b, alu_c, result;
    logic [3:0]  alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .instr_i        (instr),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_op_o       (alu_op),
        .alu_c_i        (alu_c),
        .alu_zero_i     (alu_zero),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result),
        .branch_taken_o (taken),
        .illegal_o      (illegal)
    );

    // External ALU.
    always_comb begin
        alu_c = '0;
        case (alu_op)
            4'b0000: alu_c = alu_a & alu_b;
            4'b0001: alu_c = alu_a | alu_b;
            4'b0010: alu_c = alu_a + alu_b;
            4'b0110: alu_c = alu_a - alu_b;
            default: alu_c = '0;
        endcase
    end
    assign alu_zero = (alu_c == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mnemonic index: 0 ADD 1 SUB 2 AND 3 OR 4 ADDI 5 ANDI 6 ORI 7 BEQ 8 BNE, -1 illegal.
    function automatic int mnem(input logic [31:0] w);
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        if (opc == 7'b0110011) begin
            if (f3 == 3'b000 && f7 == 7'b0000000) return 0;
            if (f3 == 3'b000 && f7 == 7'b0100000) return 1;
            if (f3 == 3'b111 && f7 == 7'b0000000) return 2;
            if (f3 == 3'b110 && f7 == 7'b0000000) return 3;
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'b000) return 4;
            if (f3 == 3'b111) return 5;
            if (f3 == 3'b110) return 6;
        end else if (opc == 7'b1100011) begin
            if (f3 == 3'b000) return 7;
            if (f3 == 3'b001) return 8;
        end
        return -1;
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int k = mnem(w);
        logic [31:0] imm = {{20{w[31]}}, w[31:20]};
        e = '0;
        e.legal = (k >= 0);
        e.a = r1;
        case (k)
            0: begin e.op = 4'b0010; e.b = r2;  e.res = r1 + r2;  end
            1: begin e.op = 4'b0110; e.b = r2;  e.res = r1 - r2;  end
            2: begin e.op = 4'b0000; e.b = r2;  e.res = r1 & r2;  end
            3: begin e.op = 4'b0001; e.b = r2;  e.res = r1 | r2;  end
            4: begin e.op = 4'b0010; e.b = imm; e.res = r1 + imm; end
            5: begin e.op = 4'b0000; e.b = imm; e.res = r1 & imm; end
            6: begin e.op = 4'b0001; e.b = imm; e.res = r1 | imm; end
            7: begin e.op = 4'b0110; e.b = r2;  e.res = r1 - r2; e.taken = (r1 == r2); end
            8: begin e.op = 4'b0110; e.b = r2;  e.res = r1 - r2; e.taken = (r1 != r2); end
            default: begin e.a = '0; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction
    function automatic logic [31:0] b_type(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    // Reference model: one outstanding transaction, response due a fixed
    // number of cycles after acceptance, retired by out_ready.
    exp_t        w_exp;
    int          cyc;
    int          m_due;
    logic        m_pending;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic        m_taken, m_ill;
    logic        m_resp;

    assign w_exp  = model(instr, rs1, rs2);
    assign m_resp = m_pending && (cyc >= m_due);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_due <= 0; m_pending <= 1'b0;
            m_a <= '0; m_b <= '0; m_op <= 4'b0010;
            m_res <= '0; m_taken <= 1'b0; m_ill <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_pending) begin
                if (m_resp && out_ready) m_pending <= 1'b0;
            end else if (in_valid) begin
                m_pending <= 1'b1;
                m_due     <= cyc + (w_exp.legal ? 2 : 1);
                m_res     <= w_exp.res;
                m_taken   <= w_exp.taken;
                m_ill     <= !w_exp.legal;
                if (w_exp.legal) begin
                    m_a  <= w_exp.a;
                    m_b  <= w_exp.b;
                    m_op <= w_exp.op;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_pending ? 32'd0 : 32'd1);
            chk("out_valid", out_valid, m_resp ? 32'd1 : 32'd0);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
            if (m_resp) begin
                chk("result", result, m_res);
                chk("branch_taken", taken, m_taken);
                chk("illegal", illegal, m_ill);
            end
        end
    end

    // Directed request with literal expectations; unit must be idle on entry.
    task automatic req(input string name, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] e_res, input logic e_taken,
                       input logic e_ill, input int e_lat, input logic [3:0] e_op);
        int n;
        @(negedge clk);
        in_valid = 1'b1; instr = ins; rs1 = r1; rs2 = r2; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, e_lat);
        chk({name, "_result"}, result, e_res);
        chk({name, "_taken"}, taken, e_taken);
        chk({name, "_illegal"}, illegal, e_ill);
        chk({name, "_op"}, alu_op, e_op);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_ready_after"}, in_ready, 1);
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 10))
            0:  return r_type(7'b0000000, 3'b000);
            1:  return r_type(7'b0100000, 3'b000);
            2:  return r_type(7'b0000000, 3'b111);
            3:  return r_type(7'b0000000, 3'b110);
            4:  return i_type(12'($urandom), 3'b000);
            5:  return i_type(12'($urandom), 3'b111);
            6:  return i_type(12'($urandom), 3'b110);
            7:  return b_type(3'b000);
            8:  return b_type(3'b001);
            9:  return r_type(7'($urandom_range(1, 127)), 3'b111);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        // Reset values.
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_taken", taken, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 32'b0010);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        req("add",  r_type(7'b0000000, 3'b000), 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2, 4'b0010);
        req("sub",  r_type(7'b0100000, 3'b000), 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2, 4'b0110);
        req("addi", i_type(12'hFFF, 3'b000), 32'd1, 32'd55, 32'd0, 1'b0, 1'b0, 2, 4'b0010);
        req("and",  r_type(7'b0000000, 3'b111), 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 2, 4'b0000);
        req("ori",  i_type(12'h00F, 3'b110), 32'h0000_0100, 32'd0, 32'h0000_010F, 1'b0, 1'b0, 2, 4'b0001);
        req("beq",  b_type(3'b000), 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2, 4'b0110);
        req("bne",  b_type(3'b001), 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 2, 4'b0110);
        req("ecall", 32'h0000_0073, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1, 4'b0110);
        chk("ecall_alu_a_kept", alu_a, 32'd9);
        chk("ecall_alu_b_kept", alu_b, 32'd9);

        // Back-pressure: response held while new requests are offered.
        @(negedge clk);
        in_valid = 1'b1; instr = r_type(7'b0000000, 3'b000); rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clk);
        instr = r_type(7'b0100000, 3'b000); rs1 = 32'd100;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            instr = rand_instr(); rs1 = $urandom;
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_result", result, 32'd7);
            chk("stall_alu_a", alu_a, 32'd3);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_retire_ready", in_ready, 1);
        chk("stall_retire_valid", out_valid, 0);

        // Reset during EXEC discards the request.
        @(negedge clk);
        in_valid = 1'b1; instr = r_type(7'b0000000, 3'b000); rs1 = 32'd20; rs2 = 32'd22;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("pre_rst_alu_a", alu_a, 32'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 32'b0010);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", out_valid, 0);
            chk("post_rst_ready", in_ready, 1);
        end

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            rs1       = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rs2       = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
